stage_writeback_seq: RTL
========================

# stage_writeback_seq

Registered, parametrised MIPS write-back stage. It holds the MEM/WB pipeline register and selects the register-file write value from ALU result, load data or link address. Load data is aligned and extended by size, offset and signedness. It waits, with a valid handshake, for variable-latency data memory. It sits between the MEM stage and the register file, and also drives the hazard unit's WB-side stall and forwarding inputs.

## Interface
Parameters:
- DATA_W, 32, datapath width; legal values 32 or 64.
- RA_W, 5, register address width.
- CNT_W, 16, width of the wait-cycle performance counter.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m_valid  in  1  MEM stage presents an instruction.
- m_ready  out  1  WB accepts the instruction this cycle.
- m_regwrite  in  1  instruction writes the register file.
- m_writereg  in  RA_W  destination register.
- m_resultsrc  in  2  00 ALU, 01 load, 10 link, 11 treated as ALU.
- m_aluresult  in  DATA_W  ALU result.
- m_linkaddr  in  DATA_W  PC+8 for JAL/JALR.
- m_loadsize  in  2  00 byte, 01 half, 10 word, 11 doubleword.
- m_loadsigned  in  1  1 means sign-extend, 0 means zero-extend.
- m_byteoff  in  log2(DATA_W/8)  byte offset of the load address.
- readdata  in  DATA_W  raw memory word.
- readdata_valid  in  1  readdata is valid this cycle.
- flush  in  1  kill the instruction held in WB.
- wb_regwrite  out  1  register-file write enable.
- wb_writereg  out  RA_W  register-file write address.
- wb_result  out  DATA_W  register-file write data, also the forwarding value.
- wb_stall  out  1  load waiting for data; the hazard unit freezes upstream.
- wait_cycles  out  CNT_W  saturating count of cycles spent in WAIT.

## Operation
- States: IDLE (empty), WAIT (load holding, data not yet returned), COMMIT (result ready to write).
- Reset: state IDLE, all latched fields 0, all outputs 0, wait_cycles 0.
- m_ready = !flush && state != WAIT.
- Capture: a transfer occurs when m_valid && m_ready; all m_* fields are registered.
  - m_resultsrc 01 → next state WAIT.
  - Any other m_resultsrc → next state COMMIT. The selected value (ALU or link) is registered as the result.
- No transfer from IDLE or COMMIT → next state IDLE.
- WAIT: readdata_valid → aligned data registered as the result, next state COMMIT. Otherwise stay in WAIT. readdata_valid is ignored in IDLE and COMMIT.
- Alignment (little-endian):
  - byte = readdata[8*off +: 8]
  - half = readdata[16*off[BW-1:1] +: 16]
  - word = readdata[32*off[BW-1:2] +: 32]
  - doubleword = readdata, legal only when DATA_W=64; with DATA_W=32, loadsize 11 is treated as word.
  - The result is sign- or zero-extended to DATA_W per m_loadsigned. Low offset bits below the access size are ignored; misalignment is not trapped.
- COMMIT: wb_regwrite = latched regwrite && writereg != 0 && !flush. The writes to r0 are suppressed.
- wb_writereg and wb_result always reflect the latched fields.
- Flush:
  - Forces wb_regwrite=0 and m_ready=0 in the same cycle; next state IDLE.
  - Flush in WAIT abandons the load; a late readdata_valid is ignored.
  - Flush has priority over capture and over readdata_valid.
- wb_stall = (state == WAIT) && !flush.
- wait_cycles increments by 1 in every WAIT cycle and saturates at 2^CNT_W-1. Only reset clears it.

## Timing
- Non-load: captured at edge E; wb_regwrite high in cycle E+1 for exactly one cycle. Throughput is 1 per cycle: COMMIT accepts the next instruction while writing.
- Load, data valid in cycle K while in WAIT: wb_regwrite high in cycle K+1. The minimum load latency is 2 cycles after capture, when data is valid in the first WAIT cycle.
- m_ready is 0 for every WAIT cycle, so back-to-back loads serialise.
- Asynchronous reset mid-WAIT or mid-COMMIT: outputs drop to 0 immediately; no write escapes.

## Test plan
- ALU op, r5 ← 0x0000_1234, then a link op to r31 with 0x0040_0008 on the next cycle → wb_regwrite pulses on consecutive cycles with matching data; m_ready stays 1.
- Load byte, signed, off=3, readdata=0x80FF_0000, valid 3 cycles after capture → wb_stall high 3 cycles, result 0xFFFF_FF80, wait_cycles=3. The same case unsigned → 0x0000_0080.
- Load half, unsigned, off=2, readdata=0xBEEF_1234 → 0x0000_BEEF. Word off=0 → 0xBEEF_1234.
- Write to r0 with m_regwrite=1 → wb_regwrite stays 0; the pipeline still advances.
- Flush during WAIT, then readdata_valid next cycle → no write; state IDLE; the next ALU op commits normally.
- rst_n low while in COMMIT → wb_regwrite 0 immediately. After release, outputs are 0 and wait_cycles=0. Saturation check with CNT_W=2: 5 WAIT cycles → wait_cycles=3.

Source files
------------

// File: rtl/stage_writeback_seq.sv
// MIPS write-back stage: MEM/WB pipeline register, result select, load alignment
// and extension, and a handshake that holds loads until data memory answers.
module stage_writeback_seq #(
  parameter  int DATA_W = 32,
  parameter  int RA_W   = 5,
  parameter  int CNT_W  = 16,
  localparam int BW     = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic              m_regwrite,
  input  logic [RA_W-1:0]   m_writereg,
  input  logic [1:0]        m_resultsrc,
  input  logic [DATA_W-1:0] m_aluresult,
  input  logic [DATA_W-1:0] m_linkaddr,
  input  logic [1:0]        m_loadsize,
  input  logic              m_loadsigned,
  input  logic [BW-1:0]     m_byteoff,
  input  logic [DATA_W-1:0] readdata,
  input  logic              readdata_valid,
  input  logic              flush,
  output logic              wb_regwrite,
  output logic [RA_W-1:0]   wb_writereg,
  output logic [DATA_W-1:0] wb_result,
  output logic              wb_stall,
  output logic [CNT_W-1:0]  wait_cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_COMMIT
  } state_t;

  state_t              state_q;
  logic                regwrite_q;
  logic [RA_W-1:0]     writereg_q;
  logic [1:0]          loadsize_q;
  logic                loadsigned_q;
  logic [BW-1:0]       byteoff_q;
  logic [DATA_W-1:0]   result_q;
  logic [CNT_W-1:0]    wait_cycles_q;

  logic [BW-1:0]       aligned_off;
  logic [DATA_W-1:0]   shifted;
  logic [DATA_W-1:0]   keep_mask;
  logic                ext_bit;
  logic [DATA_W-1:0]   load_data;

  // Alignment works off the latched load fields; readdata is only sampled in WAIT.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    aligned_off = byteoff_q;
    keep_mask   = '0;
    case (loadsize_q)
      2'b00: keep_mask[7:0] = '1;
      2'b01: begin
        aligned_off     = byteoff_q & ~BW'(1);
        keep_mask[15:0] = '1;
      end
      2'b10: begin
        aligned_off     = byteoff_q & ~BW'(3);
        keep_mask[31:0] = '1;
      end
      default: begin
        if (DATA_W == 64) begin
          aligned_off = '0;
          keep_mask   = '1;
        end else begin
          aligned_off     = byteoff_q & ~BW'(3);
          keep_mask[31:0] = '1;
        end
      end
    endcase
    shifted   = readdata >> {aligned_off, 3'b000};
    // The top set bit of the mask picks out the sign bit of the access.
    ext_bit   = loadsigned_q & (|(shifted & keep_mask & ~(keep_mask >> 1)));
    load_data = (shifted & keep_mask) | ({DATA_W{ext_bit}} & ~keep_mask);
  end

  assign m_ready     = !flush && (state_q != S_WAIT);
  assign wb_regwrite = (state_q == S_COMMIT) && regwrite_q && (writereg_q != '0) && !flush;
  assign wb_stall    = (state_q == S_WAIT) && !flush;
  assign wb_writereg = writereg_q;
  assign wb_result   = result_q;
  assign wait_cycles = wait_cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every pipeline field is reset, so nothing stale reaches the register file after reset.
    if (!rst_n) begin
      state_q       <= S_IDLE;
      regwrite_q    <= 1'b0;
      writereg_q    <= '0;
      loadsize_q    <= '0;
      loadsigned_q  <= 1'b0;
      byteoff_q     <= '0;
      result_q      <= '0;
      wait_cycles_q <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      if (state_q == S_WAIT && wait_cycles_q != '1)
        wait_cycles_q <= wait_cycles_q + CNT_W'(1);

      if (flush) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_WAIT: begin
            if (readdata_valid) begin
              result_q <= load_data;
              state_q  <= S_COMMIT;
            end
          end
          default: begin
            if (m_valid) begin
              regwrite_q   <= m_regwrite;
              writereg_q   <= m_writereg;
              loadsize_q   <= m_loadsize;
              loadsigned_q <= m_loadsigned;
              byteoff_q    <= m_byteoff;
              if (m_resultsrc == 2'b01) begin
                state_q <= S_WAIT;
              end else begin
                result_q <= (m_resultsrc == 2'b10) ? m_linkaddr : m_aluresult;
                state_q  <= S_COMMIT;
              end
            end else begin
              state_q <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule
